fft_result_streamer: RTL and testbench
======================================

Name: fft_result_streamer

Overview:
- Read-side counterpart of the radix-2 FFT control unit. Once the control unit raises fft_ready, this block drains the FFT result BRAM and emits the samples on a valid/ready output stream.
- Converts the bit-reversed storage order to natural output order, absorbs the 1-cycle BRAM read latency with a 2-entry buffer, and sustains 1 word/cycle under continuous ready.
- Sits between the result BRAM read port and the downstream consumer (DMA/host interface).

Parameters:
- ADDR_W, 9, BRAM address width.
- N_WORDS, 512, number of result words per frame; must equal 2**ADDR_W when BIT_REV=1.
- DATA_W, 32, word width ({re[15:0], im[15:0]}, passed through untouched).
- BIT_REV, 1, 1 = BRAM address is bit-reverse(index); 0 = address equals index.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- fft_ready_i  in  1  frame ready; sampled only in S_IDLE.
- bram_re_o  out  1  BRAM read enable.
- bram_addr_o  out  ADDR_W  BRAM read address.
- bram_rdata_i  in  DATA_W  BRAM read data, valid the cycle after bram_re_o.
- m_data_o  out  DATA_W  output sample.
- m_index_o  out  ADDR_W  natural-order index of m_data_o.
- m_valid_o  out  1  output valid.
- m_ready_i  in  1  downstream ready.
- m_last_o  out  1  high with index N_WORDS-1.
- busy_o  out  1  high in any state other than S_IDLE.
- done_o  out  1  1-cycle pulse after the last word is accepted.

Behaviour:
- Reset: one clock, synchronous, active-high. Every output is 0 after reset. The 2-entry buffer is emptied, the counters are cleared, and the in-flight read flag is cleared. A rst asserted mid-frame aborts the frame; the next cycle shows m_valid_o=0, bram_re_o=0, busy_o=0.
- States:
  - S_IDLE: on fft_ready_i=1, go to S_READ with rd_idx=0 and out_idx=0. Otherwise stay.
  - S_READ: issue reads. After the read with rd_idx=N_WORDS-1 is issued, go to S_DRAIN.
  - S_DRAIN: no reads. When the transfer with m_last_o=1 completes (m_valid_o & m_ready_i), go to S_DONE.
  - S_DONE: done_o=1 for exactly one cycle, then S_IDLE.
- Read issue:
  - In S_READ, bram_re_o=1 when (buf_count + inflight - pop) < 2, where pop = m_valid_o & m_ready_i in the same cycle. This combinational path from m_ready_i is permitted.
  - bram_addr_o = bitrev(rd_idx) if BIT_REV else rd_idx. rd_idx increments on each issue.
  - bram_addr_o is don't-care when bram_re_o=0; the bench must not check it then.
- Capture: bram_rdata_i is written into the buffer the cycle after an issue. The buffer never overflows; overflow is an assertion failure.
- Output stream:
  - m_valid_o = buffer not empty. m_data_o, m_index_o and m_last_o come from the buffer head.
  - While m_valid_o & !m_ready_i, all output fields stay stable.
  - m_index_o counts 0..N_WORDS-1 in order. m_last_o = (m_index_o == N_WORDS-1).
- Latency: fft_ready_i high in S_IDLE at cycle 0 gives:
  - first bram_re_o in cycle 1;
  - first m_valid_o in cycle 3;
  - with m_ready_i held high, one word per cycle and last word in cycle N_WORDS+2;
  - done_o in cycle N_WORDS+3.
- fft_ready_i is ignored when not in S_IDLE, including in S_DONE. A level held high restarts a new frame from S_IDLE.
- Counters are ADDR_W+1 bits wide so the N_WORDS terminal value cannot alias to 0.

Test Plan:
- ADDR_W=3, N_WORDS=8, BIT_REV=1; the BRAM model returns mem[a]=a*32'h0101, 1-cycle latency; m_ready_i=1; fft_ready_i pulsed at cycle 0.
  -> Reads in cycles 1..8 to addresses 0,4,2,6,1,5,3,7.
  -> m_valid_o in cycles 3..10 with m_index_o 0..7 and data 0,0x404,0x202,0x606,0x101,0x505,0x303,0x707.
  -> m_last_o only in cycle 10; done_o only in cycle 11; busy_o in cycles 1..11.
- Same setup with m_ready_i=0 in cycles 3..6.
  -> m_data_o holds 0 and m_index_o holds 0 through cycle 6.
  -> At most 2 reads complete ahead of output (no more than 3 total issued through cycle 6).
  -> All 8 words then arrive in order, with no loss or duplication.
- BIT_REV=0, N_WORDS=8, m_ready_i=1.
  -> Read addresses 0..7 in order.
  -> Output data equals mem[index].
- fft_ready_i pulsed again in cycles 5 and 11 of frame 1.
  -> Both pulses are ignored.
  -> A pulse at cycle 14 starts frame 2, identical to frame 1.
- rst asserted in cycle 5 of a frame.
  -> Cycle 6: m_valid_o=0, bram_re_o=0, busy_o=0, done_o=0.
  -> The next fft_ready_i starts at index 0, address 0.
- Random m_ready_i (50%), 20 frames.
  -> Every frame delivers exactly 8 words, indices 0..7 in order, with data matching the model.
  -> Exactly one m_last_o and one done_o per frame.

Source files
------------

// File: rtl/fft_result_streamer.sv
// fft_result_streamer
//
// Drains one frame of FFT results from the result BRAM once the FFT control
// unit raises fft_ready_i, and presents the samples in natural order on a
// valid/ready stream. The BRAM holds results in bit-reversed order, so the
// read address is the bit-reverse of the natural index when BIT_REV=1.
// A 2-entry buffer absorbs the 1-cycle BRAM read latency, so the stream
// sustains 1 word/cycle while m_ready_i stays high.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   fft_ready_i   frame ready, only looked at in S_IDLE
//   bram_re_o     BRAM read enable
//   bram_addr_o   BRAM read address (meaningful only with bram_re_o)
//   bram_rdata_i  BRAM read data, valid the cycle after bram_re_o
//   m_data_o      output sample (buffer head)
//   m_index_o     natural-order index of m_data_o
//   m_valid_o     output valid (buffer not empty)
//   m_ready_i     downstream ready
//   m_last_o      high with the final index of the frame
//   busy_o        high whenever not in S_IDLE
//   done_o        1-cycle pulse after the last word is accepted

module fft_result_streamer #(
   parameter int ADDR_W  = 9,
   parameter int N_WORDS = 512,
   parameter int DATA_W  = 32,
   parameter int BIT_REV = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fft_ready_i,
   output logic              bram_re_o,
   output logic [ADDR_W-1:0] bram_addr_o,
   input  logic [DATA_W-1:0] bram_rdata_i,
   output logic [DATA_W-1:0] m_data_o,
   output logic [ADDR_W-1:0] m_index_o,
   output logic              m_valid_o,
   input  logic              m_ready_i,
   output logic              m_last_o,
   output logic              busy_o,
   output logic              done_o
);

   // One extra bit so the terminal value N_WORDS never aliases to 0.
   localparam int CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_WORDS - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] rd_idx_q, rd_idx_d;
   logic [CNT_W-1:0] out_idx_q, out_idx_d;
   logic             inflight_q, inflight_d;

   logic [DATA_W-1:0] buf_data_q [2];
   logic [DATA_W-1:0] buf_data_d [2];
   logic              buf_wr_ptr_q, buf_wr_ptr_d;
   logic              buf_rd_ptr_q, buf_rd_ptr_d;
   logic [1:0]        buf_count_q, buf_count_d;

   logic       pop;
   logic       push;
   logic       issue;
   logic [2:0] occupancy;

   function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] r;
      r = '0;
      for (int i = 0; i < ADDR_W; i++) begin
         r[i] = a[ADDR_W-1-i];
      end
      return r;
   endfunction

   // Stream side
   always_comb begin
      m_valid_o = (buf_count_q != 2'd0);
      m_data_o  = buf_data_q[buf_rd_ptr_q];
      m_index_o = out_idx_q[ADDR_W-1:0];
      m_last_o  = m_valid_o && (out_idx_q == LAST_IDX);
      busy_o    = (state_q != S_IDLE);
      done_o    = (state_q == S_DONE);
   end

   // Read issue: count the slot freed by a same-cycle pop so that reads keep
   // flowing back-to-back under continuous ready without overfilling.
   always_comb begin
      pop         = m_valid_o && m_ready_i;
      push        = inflight_q;
      occupancy   = 3'(buf_count_q) + 3'(inflight_q) - 3'(pop);
      issue       = (state_q == S_READ) && (occupancy < 3'd2);
      bram_re_o   = issue;
      bram_addr_o = (BIT_REV != 0) ? bitrev(rd_idx_q[ADDR_W-1:0]) : rd_idx_q[ADDR_W-1:0];
   end

   // 2-entry buffer
   always_comb begin
      buf_data_d = buf_data_q;
      if (push) begin
         buf_data_d[buf_wr_ptr_q] = bram_rdata_i;
      end
      buf_wr_ptr_d = buf_wr_ptr_q ^ push;
      buf_rd_ptr_d = buf_rd_ptr_q ^ pop;
      buf_count_d  = buf_count_q + 2'(push) - 2'(pop);
      inflight_d   = issue;
   end

   // Control FSM and counters
   always_comb begin
      state_d   = state_q;
      rd_idx_d  = rd_idx_q;
      out_idx_d = out_idx_q;
      if (pop) begin
         out_idx_d = out_idx_q + CNT_W'(1);
      end
      case (state_q)
         S_IDLE: begin
            if (fft_ready_i) begin
               state_d   = S_READ;
               rd_idx_d  = '0;
               out_idx_d = '0;
            end
         end
         S_READ: begin
            if (issue) begin
               rd_idx_d = rd_idx_q + CNT_W'(1);
               if (rd_idx_q == LAST_IDX) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (pop && m_last_o) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         rd_idx_q      <= '0;
         out_idx_q     <= '0;
         inflight_q    <= 1'b0;
         buf_data_q[0] <= '0;
         buf_data_q[1] <= '0;
         buf_wr_ptr_q  <= 1'b0;
         buf_rd_ptr_q  <= 1'b0;
         buf_count_q   <= 2'd0;
      end else begin
         state_q      <= state_d;
         rd_idx_q     <= rd_idx_d;
         out_idx_q    <= out_idx_d;
         inflight_q   <= inflight_d;
         buf_data_q   <= buf_data_d;
         buf_wr_ptr_q <= buf_wr_ptr_d;
         buf_rd_ptr_q <= buf_rd_ptr_d;
         buf_count_q  <= buf_count_d;
      end
   end

   // The issue rule must make a capture into a full, unpopped buffer impossible.
   buf_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && !pop && (buf_count_q == 2'd2)));

endmodule

// File: tb/tb_fft_result_streamer.sv
// tb_fft_result_streamer
//
// Directed bench for fft_result_streamer with an 8-word frame. Instance A
// uses bit-reversed addressing, instance B linear addressing. Each BRAM model
// returns mem[a] = a * 32'h0101 one cycle after the read. Inputs change 1
// time unit after the rising edge; outputs are sampled on the falling edge.

module tb_fft_result_streamer;

   localparam int ADDR_W  = 3;
   localparam int N_WORDS = 8;
   localparam int DATA_W  = 32;

   localparam logic [2:0] REV_TAB [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

   logic clk;
   logic rst;

   logic              fft_a, rdy_a, re_a, valid_a, last_a, busy_a, done_a;
   logic [ADDR_W-1:0] addr_a, idx_a;
   logic [DATA_W-1:0] rdata_a, data_a;

   logic              fft_b, rdy_b, re_b, valid_b, last_b, busy_b, done_b;
   logic [ADDR_W-1:0] addr_b, idx_b;
   logic [DATA_W-1:0] rdata_b, data_b;

   int n_cmp;
   int n_err;

   fft_result_streamer #(
      .ADDR_W (ADDR_W),
      .N_WORDS(N_WORDS),
      .DATA_W (DATA_W),
      .BIT_REV(1)
   ) u_dut_a (
      .clk         (clk),
      .rst         (rst),
      .fft_ready_i (fft_a),
      .bram_re_o   (re_a),
      .bram_addr_o (addr_a),
      .bram_rdata_i(rdata_a),
      .m_data_o    (data_a),
      .m_index_o   (idx_a),
      .m_valid_o   (valid_a),
      .m_ready_i   (rdy_a),
      .m_last_o    (last_a),
      .busy_o      (busy_a),
      .done_o      (done_a)
   );

   fft_result_streamer #(
      .ADDR_W (ADDR_W),
      .N_WORDS(N_WORDS),
      .DATA_W (DATA_W),
      .BIT_REV(0)
   ) u_dut_b (
      .clk         (clk),
      .rst         (rst),
      .fft_ready_i (fft_b),
      .bram_re_o   (re_b),
      .bram_addr_o (addr_b),
      .bram_rdata_i(rdata_b),
      .m_data_o    (data_b),
      .m_index_o   (idx_b),
      .m_valid_o   (valid_b),
      .m_ready_i   (rdy_b),
      .m_last_o    (last_b),
      .busy_o      (busy_b),
      .done_o      (done_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // BRAM models, 1-cycle read latency
   always_ff @(posedge clk) begin
      if (re_a) rdata_a <= 32'(addr_a) * 32'h0101;
      if (re_b) rdata_b <= 32'(addr_b) * 32'h0101;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Address of the n-th read, and data expected at natural index n
   function automatic logic [2:0] exp_addr(input bit sel, input int n);
      logic [2:0] k;
      k = n[2:0];
      return sel ? k : REV_TAB[k];
   endfunction

   function automatic logic [31:0] exp_data(input bit sel, input int n);
      return 32'(exp_addr(sel, n)) * 32'h0101;
   endfunction

   // Runs one frame starting with the fft_ready pulse in cycle 0.
   // mode: 0 ready high, 1 ready low in cycles 3..6, 2 random ready.
   // extra: also pulse fft_ready in cycles 5 and 11.
   task automatic run_frame(input bit sel, input int mode, input bit extra, input int budget,
                            output int done_cyc);
      int   n_rd, n_acc, n_last, n_done;
      logic f, r;
      logic o_re, o_valid, o_last, o_done;
      logic [2:0]  o_addr, o_idx;
      logic [31:0] o_data;
      n_rd = 0; n_acc = 0; n_last = 0; n_done = 0;
      done_cyc = -1;
      for (int c = 0; c < budget; c++) begin
         f = (c == 0) || (extra && (c == 5 || c == 11));
         case (mode)
            0:       r = 1'b1;
            1:       r = !(c >= 3 && c <= 6);
            default: r = 1'($urandom_range(0, 1));
         endcase
         if (sel) begin fft_b = f; rdy_b = r; end
         else     begin fft_a = f; rdy_a = r; end
         @(negedge clk);
         o_re    = sel ? re_b    : re_a;
         o_addr  = sel ? addr_b  : addr_a;
         o_valid = sel ? valid_b : valid_a;
         o_idx   = sel ? idx_b   : idx_a;
         o_data  = sel ? data_b  : data_a;
         o_last  = sel ? last_b  : last_a;
         o_done  = sel ? done_b  : done_a;
         if (o_re) begin
            if (n_rd < N_WORDS) check("rd_addr", 32'(o_addr), 32'(exp_addr(sel, n_rd)));
            n_rd++;
         end
         if (o_valid) begin
            check("out_index", 32'(o_idx), 32'(n_acc));
            check("out_data", o_data, exp_data(sel, n_acc));
            check("out_last", 32'(o_last), 32'(n_acc == N_WORDS - 1));
            if (r) begin
               n_acc++;
               if (o_last) n_last++;
            end
         end
         if (mode == 1 && c >= 3 && c <= 6) check("stall_valid", 32'(o_valid), 32'd1);
         if (mode == 1 && c == 6) check("stall_reads_ahead", 32'(n_rd <= 3), 32'd1);
         if (o_done) begin
            n_done++;
            done_cyc = c;
         end
         @(posedge clk);
         #1;
         if (n_done != 0) break;
      end
      fft_a = 1'b0;
      fft_b = 1'b0;
      check("frame_timeout", 32'(n_done != 0), 32'd1);
      check("frame_words", 32'(n_acc), 32'(N_WORDS));
      check("frame_reads", 32'(n_rd), 32'(N_WORDS));
      check("frame_lasts", 32'(n_last), 32'd1);
      check("frame_dones", 32'(n_done), 32'd1);
   endtask

   initial begin
      int dc;
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b1;
      fft_a = 1'b0; rdy_a = 1'b1;
      fft_b = 1'b0; rdy_b = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_valid", 32'(valid_a), 32'd0);
      check("rst_re", 32'(re_a), 32'd0);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_done", 32'(done_a), 32'd0);
      check("rst_last", 32'(last_a), 32'd0);
      check("rst_data", data_a, 32'd0);
      check("rst_index", 32'(idx_a), 32'd0);
      @(posedge clk);
      #1;

      // Cycle-exact frame, bit-reversed, ready always high
      for (int c = 0; c <= 12; c++) begin
         fft_a = (c == 0);
         rdy_a = 1'b1;
         @(negedge clk);
         check("s1_re", 32'(re_a), 32'(c >= 1 && c <= 8));
         if (re_a && c >= 1 && c <= 8) check("s1_addr", 32'(addr_a), 32'(REV_TAB[c-1]));
         check("s1_valid", 32'(valid_a), 32'(c >= 3 && c <= 10));
         if (c >= 3 && c <= 10) begin
            check("s1_index", 32'(idx_a), 32'(c - 3));
            check("s1_data", data_a, 32'(REV_TAB[c-3]) * 32'h0101);
         end
         check("s1_last", 32'(last_a), 32'(c == 10));
         check("s1_done", 32'(done_a), 32'(c == 11));
         check("s1_busy", 32'(busy_a), 32'(c >= 1 && c <= 11));
         @(posedge clk);
         #1;
      end

      // Backpressure in cycles 3..6
      run_frame(1'b0, 1, 1'b0, 60, dc);
      check("s2_done_cycle", 32'(dc), 32'd15);

      // Linear addressing
      run_frame(1'b1, 0, 1'b0, 60, dc);
      check("s3_done_cycle", 32'(dc), 32'd11);

      // Extra fft_ready pulses in cycles 5 and 11 are ignored
      run_frame(1'b0, 0, 1'b1, 60, dc);
      check("s4_done_cycle", 32'(dc), 32'd11);
      for (int c = 12; c <= 13; c++) begin
         @(negedge clk);
         check("s4_idle_busy", 32'(busy_a), 32'd0);
         check("s4_idle_re", 32'(re_a), 32'd0);
         @(posedge clk);
         #1;
      end
      run_frame(1'b0, 0, 1'b0, 60, dc);
      check("s4_frame2_done_cycle", 32'(dc), 32'd11);

      // Reset in cycle 5 aborts the frame
      for (int c = 0; c <= 5; c++) begin
         fft_a = (c == 0);
         rdy_a = 1'b1;
         rst   = (c == 5);
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      @(negedge clk);
      check("s5_valid", 32'(valid_a), 32'd0);
      check("s5_re", 32'(re_a), 32'd0);
      check("s5_busy", 32'(busy_a), 32'd0);
      check("s5_done", 32'(done_a), 32'd0);
      @(posedge clk);
      #1;
      run_frame(1'b0, 0, 1'b0, 60, dc);
      check("s5_done_cycle", 32'(dc), 32'd11);

      // Random backpressure
      for (int f = 0; f < 20; f++) begin
         run_frame(1'b0, 2, 1'b0, 200, dc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
